// File: rtl/semaphore_pkg.sv
// semaphore_pkg: default cycle constants for the 50 MHz board and a counter-width helper
package semaphore_pkg;
  localparam int CYC_5S = 250_000_000;
  localparam int CYC_7S = 350_000_000;
  localparam int CYC_05S = 25_000_000;
  localparam int DEBOUNCE_CYC = 500_000;
  localparam int MIN_GREEN_CYC = 50_000_000;
  function automatic int cw(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/semaphore_timer.sv
// semaphore_timer: saturating phase timer, counts to N-1 while load is high
// ports: clk, rst (async, active-high), load (count enable), clear (has priority),
//        cnt (current count), fim (count saturated at N-1)
module semaphore_timer
  import semaphore_pkg::*;
#(
  parameter int N = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  output logic [cw(N)-1:0] cnt,
  output logic             fim
);
  localparam int W = cw(N);
  localparam logic [W-1:0] LAST = W'(N - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (load && cnt != LAST) cnt <= cnt + 1'b1;
  assign fim = cnt == LAST;
endmodule

// File: rtl/semaphore_datapath.sv
// semaphore_datapath: phase timers plus pedestrian button synchroniser, debouncer and request latch
// ports: clk, rst (async, active-high), ped_btn (raw button), load_/clear_Reg{5s,7s,05s}
//        (timer strobes from the controller), fim_{5s,7s,05s} (timer expired),
//        pedestrian (pending request, shown only after minimum green)
module semaphore_datapath #(
  parameter int CYC_5S = semaphore_pkg::CYC_5S,
  parameter int CYC_7S = semaphore_pkg::CYC_7S,
  parameter int CYC_05S = semaphore_pkg::CYC_05S,
  parameter int DEBOUNCE_CYC = semaphore_pkg::DEBOUNCE_CYC,
  parameter int MIN_GREEN_CYC = semaphore_pkg::MIN_GREEN_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic ped_btn,
  input  logic load_Reg5s,
  input  logic clear_Reg5s,
  input  logic load_Reg7s,
  input  logic clear_Reg7s,
  input  logic load_Reg05s,
  input  logic clear_Reg05s,
  output logic fim_5s,
  output logic fim_7s,
  output logic fim_05s,
  output logic pedestrian
);
  import semaphore_pkg::*;
  localparam int W5 = cw(CYC_5S);
  localparam int W7 = cw(CYC_7S);
  localparam int W05 = cw(CYC_05S);
  localparam int DW = cw(DEBOUNCE_CYC);
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYC - 1);
  localparam logic [W7-1:0] MIN_G = W7'(MIN_GREEN_CYC - 1);
  logic [W5-1:0] cnt5;
  logic [W7-1:0] cnt7;
  logic [W05-1:0] cnt05;
  logic s1, s2, db, req;
  logic [DW-1:0] dcnt;
  logic db_rise;
  logic unused_cnt;
  semaphore_timer #(.N(CYC_5S)) u_t5 (
    .clk(clk), .rst(rst), .load(load_Reg5s), .clear(clear_Reg5s), .cnt(cnt5), .fim(fim_5s)
  );
  semaphore_timer #(.N(CYC_7S)) u_t7 (
    .clk(clk), .rst(rst), .load(load_Reg7s), .clear(clear_Reg7s), .cnt(cnt7), .fim(fim_7s)
  );
  semaphore_timer #(.N(CYC_05S)) u_t05 (
    .clk(clk), .rst(rst), .load(load_Reg05s), .clear(clear_Reg05s), .cnt(cnt05), .fim(fim_05s)
  );
  assign unused_cnt = ^{cnt5, cnt05};
  // the accepting edge of a 0->1 debounced transition
  assign db_rise = s2 && !db && dcnt == DLAST;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      db <= 1'b0;
      dcnt <= '0;
      req <= 1'b0;
    end else begin
      s1 <= ped_btn;
      s2 <= s1;
      if (s2 == db) dcnt <= '0;
      else if (dcnt == DLAST) begin
        db <= s2;
        dcnt <= '0;
      end else dcnt <= dcnt + 1'b1;
      // servicing (yellow) beats a press landing on the same edge
      req <= load_Reg05s ? 1'b0 : db_rise ? 1'b1 : req;
    end
  assign pedestrian = req && load_Reg7s && cnt7 >= MIN_G;
endmodule

// File: tb/tb_semaphore_datapath.sv
// tb_semaphore_datapath: directed stimulus checked against a behavioural model and literal expectations
module tb_semaphore_datapath;
  localparam int C5 = 5, C7 = 7, C05 = 2, DB = 4, MG = 3;
  logic clk = 0, rst = 0, ped_btn = 0;
  logic load5 = 0, clear5 = 0, load7 = 0, clear7 = 0, load05 = 0, clear05 = 0;
  logic fim_5s, fim_7s, fim_05s, pedestrian;
  int n_tests = 0, n_fail = 0;
  int m_t5 = 0, m_t7 = 0, m_t05 = 0, m_run = 0;
  bit m_s1 = 0, m_s2 = 0, m_db = 0, m_req = 0;

  semaphore_datapath #(
    .CYC_5S(C5), .CYC_7S(C7), .CYC_05S(C05), .DEBOUNCE_CYC(DB), .MIN_GREEN_CYC(MG)
  ) dut (
    .clk(clk), .rst(rst), .ped_btn(ped_btn),
    .load_Reg5s(load5), .clear_Reg5s(clear5),
    .load_Reg7s(load7), .clear_Reg7s(clear7),
    .load_Reg05s(load05), .clear_Reg05s(clear05),
    .fim_5s(fim_5s), .fim_7s(fim_7s), .fim_05s(fim_05s), .pedestrian(pedestrian)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int tstep(input int t, input bit ld, input bit cl, input int n);
    if (cl) return 0;
    if (ld) return t + 1 > n - 1 ? n - 1 : t + 1;
    return t;
  endfunction

  // model: timers as saturating integers; the button is accepted once the
  // synchronised level has disagreed with the accepted level for DB consecutive edges
  always @(posedge clk or posedge rst) begin
    bit rose;
    if (rst) begin
      m_t5 = 0; m_t7 = 0; m_t05 = 0; m_run = 0;
      m_s1 = 0; m_s2 = 0; m_db = 0; m_req = 0;
    end else begin
      m_t5 = tstep(m_t5, load5, clear5, C5);
      m_t7 = tstep(m_t7, load7, clear7, C7);
      m_t05 = tstep(m_t05, load05, clear05, C05);
      rose = 0;
      m_run = m_s2 != m_db ? m_run + 1 : 0;
      if (m_run == DB) begin
        m_db = m_s2;
        m_run = 0;
        rose = m_db;
      end
      if (load05) m_req = 0;
      else if (rose) m_req = 1;
      m_s2 = m_s1;
      m_s1 = ped_btn;
    end
  end

  always @(negedge clk) begin
    chk("m_fim_5s", int'(fim_5s), int'(m_t5 == C5 - 1));
    chk("m_fim_7s", int'(fim_7s), int'(m_t7 == C7 - 1));
    chk("m_fim_05s", int'(fim_05s), int'(m_t05 == C05 - 1));
    chk("m_pedestrian", int'(pedestrian), int'(m_req && load7 && m_t7 >= MG - 1));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    bit burst[8] = '{1, 1, 1, 0, 1, 1, 1, 1};
    int lat;
    #1 rst = 1;
    #1 chk("reset_fim_5s", int'(fim_5s), 0);
    chk("reset_pedestrian", int'(pedestrian), 0);
    step();
    step();
    rst = 0;
    load5 = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("red_low", int'(fim_5s), 0);
    end
    @(negedge clk);
    chk("red_high", int'(fim_5s), 1);
    repeat (3) begin
      @(negedge clk);
      chk("red_hold", int'(fim_5s), 1);
    end
    step();
    clear5 = 1;
    @(negedge clk);
    chk("red_clear_pending", int'(fim_5s), 1);
    step();
    clear5 = 0;
    load5 = 0;
    @(negedge clk);
    chk("red_cleared", int'(fim_5s), 0);
    step();
    load7 = 1;
    clear7 = 1;
    repeat (10) begin
      @(negedge clk);
      chk("clear_priority", int'(fim_7s), 0);
    end
    step();
    clear7 = 0;
    repeat (3) step();
    foreach (burst[i]) if (i < 3) begin
      ped_btn = i < 2;
      step();
    end
    repeat (8) begin
      @(negedge clk);
      chk("short_burst", int'(pedestrian), 0);
    end
    step();
    foreach (burst[i]) begin
      ped_btn = burst[i];
      if (i < 7) step();
    end
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pedestrian) begin
        lat = i;
        break;
      end
    end
    chk("bounce_latency", lat, 3);
    step();
    ped_btn = 0;
    repeat (8) @(negedge clk);
    chk("release_keeps_req", int'(pedestrian), 1);
    step();
    load05 = 1;
    step();
    load05 = 0;
    @(negedge clk);
    chk("service_clears", int'(pedestrian), 0);
    step();
    ped_btn = 1;
    repeat (5) step();
    load05 = 1;
    step();
    load05 = 0;
    repeat (4) begin
      @(negedge clk);
      chk("same_edge_discard", int'(pedestrian), 0);
    end
    step();
    ped_btn = 0;
    repeat (10) step();
    load7 = 0;
    clear7 = 1;
    load5 = 1;
    ped_btn = 1;
    step();
    clear7 = 0;
    repeat (8) step();
    ped_btn = 0;
    load5 = 0;
    load7 = 1;
    @(negedge clk);
    chk("min_green_c0", int'(pedestrian), 0);
    @(negedge clk);
    chk("min_green_c1", int'(pedestrian), 0);
    @(negedge clk);
    chk("min_green_c2", int'(pedestrian), 1);
    repeat (4) @(negedge clk);
    chk("green_fim", int'(fim_7s), 1);
    chk("green_ped", int'(pedestrian), 1);
    step();
    rst = 1;
    #1;
    chk("async_fim_7s", int'(fim_7s), 0);
    chk("async_pedestrian", int'(pedestrian), 0);
    chk("async_fim_5s", int'(fim_5s), 0);
    chk("async_fim_05s", int'(fim_05s), 0);
    load7 = 0;
    step();
    step();
    rst = 0;
    load5 = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_reset_red_low", int'(fim_5s), 0);
    end
    @(negedge clk);
    chk("post_reset_red_high", int'(fim_5s), 1);
    step();
    load5 = 0;
    load7 = 1;
    repeat (6) @(negedge clk);
    chk("req_lost", int'(pedestrian), 0);
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
